// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: round-robin EX/MEM onto the single regfile write port,
// plus a per-register pending-write scoreboard used by decode to stall on RAW hazards.
module riscv_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            ex_valid_in,
  input  logic [4:0]      ex_rd_in,
  input  logic [XLEN-1:0] ex_wd_in,
  output logic            ex_ready_out,
  input  logic            mem_valid_in,
  input  logic [4:0]      mem_rd_in,
  input  logic [XLEN-1:0] mem_wd_in,
  output logic            mem_ready_out,
  input  logic            issue_valid_in,
  input  logic [4:0]      issue_rd_in,
  input  logic [4:0]      ra_in,
  input  logic [4:0]      rb_in,
  output logic            ra_busy_out,
  output logic            rb_busy_out,
  output logic            rf_we_out,
  output logic [4:0]      rf_rd_out,
  output logic [XLEN-1:0] rf_wd_out
);

  localparam logic GRANT_EX  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  logic             last_grant_q, last_grant_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_wd_q, rf_wd_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic             ex_acc, mem_acc;

  // Grants are gated by reset so the handshakes stay quiet while held in reset.
  always_comb begin
    ex_acc  = 1'b0;
    mem_acc = 1'b0;
    if (rst_n_in) begin
      if (ex_valid_in && mem_valid_in) begin
        ex_acc  = (last_grant_q == GRANT_MEM);
        mem_acc = (last_grant_q == GRANT_EX);
      end else begin
        ex_acc  = ex_valid_in;
        mem_acc = mem_valid_in;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wd_d      = rf_wd_q;
    if (ex_acc) begin
      last_grant_d = GRANT_EX;
      rf_we_d      = (ex_rd_in != 5'd0);
      rf_rd_d      = ex_rd_in;
      rf_wd_d      = ex_wd_in;
    end else if (mem_acc) begin
      last_grant_d = GRANT_MEM;
      rf_we_d      = (mem_rd_in != 5'd0);
      rf_rd_d      = mem_rd_in;
      rf_wd_d      = mem_wd_in;
    end
  end

  // Set is applied after clear: a newly issued producer outranks the retiring one.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[rf_rd_q] = 1'b0;
    end
    if (issue_valid_in) begin
      pending_d[issue_rd_in] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_grant_q <= GRANT_MEM;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wd_q      <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wd_q      <= rf_wd_d;
      pending_q    <= pending_d;
    end
  end

  assign ex_ready_out  = ex_acc;
  assign mem_ready_out = mem_acc;
  assign ra_busy_out   = rst_n_in & pending_q[ra_in];
  assign rb_busy_out   = rst_n_in & pending_q[rb_in];
  assign rf_we_out     = rf_we_q;
  assign rf_rd_out     = rf_rd_q;
  assign rf_wd_out     = rf_wd_q;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Scoreboard bench for riscv_wb_arbiter: stimulus pushes expected handshakes and
// writes, a negedge monitor pops and compares against what the DUT presents.
module tb_riscv_wb_arbiter;
  localparam int XLEN = 32;

  logic            clk_in = 1'b0;
  logic            rst_n_in = 1'b0;
  logic            ex_valid_in = 1'b0;
  logic [4:0]      ex_rd_in = '0;
  logic [XLEN-1:0] ex_wd_in = '0;
  logic            ex_ready_out;
  logic            mem_valid_in = 1'b0;
  logic [4:0]      mem_rd_in = '0;
  logic [XLEN-1:0] mem_wd_in = '0;
  logic            mem_ready_out;
  logic            issue_valid_in = 1'b0;
  logic [4:0]      issue_rd_in = '0;
  logic [4:0]      ra_in = '0;
  logic [4:0]      rb_in = '0;
  logic            ra_busy_out;
  logic            rb_busy_out;
  logic            rf_we_out;
  logic [4:0]      rf_rd_out;
  logic [XLEN-1:0] rf_wd_out;

  riscv_wb_arbiter #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .ex_valid_in(ex_valid_in), .ex_rd_in(ex_rd_in), .ex_wd_in(ex_wd_in), .ex_ready_out(ex_ready_out),
    .mem_valid_in(mem_valid_in), .mem_rd_in(mem_rd_in), .mem_wd_in(mem_wd_in), .mem_ready_out(mem_ready_out),
    .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
    .ra_in(ra_in), .rb_in(rb_in), .ra_busy_out(ra_busy_out), .rb_busy_out(rb_busy_out),
    .rf_we_out(rf_we_out), .rf_rd_out(rf_rd_out), .rf_wd_out(rf_wd_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {int cyc; logic [4:0] rd; logic [31:0] wd;} wr_t;
  typedef struct {int cyc; bit ex_r; bit mem_r; bit ra_b; bit rb_b;} chk_t;

  wr_t  wr_q[$];
  chk_t chk_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  // Reference model: last winner (1 = MEM), pending set, and a write landing next cycle.
  bit          m_last = 1'b1;
  bit          m_pend[32];
  bit          m_clr_v = 1'b0;
  logic [4:0]  m_clr_rd = '0;
  logic [31:0] m_rf[32]  = '{default: '0};
  logic [31:0] tb_rf[32] = '{default: '0};

  always @(posedge clk_in) if (rf_we_out) tb_rf[rf_rd_out] <= rf_wd_out;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin : monitor
    chk_t c;
    wr_t  w;
    if (mon_en) begin
      while (chk_q.size() > 0 && chk_q[0].cyc < cyc) void'(chk_q.pop_front());
      if (chk_q.size() > 0 && chk_q[0].cyc == cyc) begin
        c = chk_q.pop_front();
        check("ex_ready", ex_ready_out, c.ex_r);
        check("mem_ready", mem_ready_out, c.mem_r);
        check("ra_busy", ra_busy_out, c.ra_b);
        check("rb_busy", rb_busy_out, c.rb_b);
      end
      if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
        w = wr_q.pop_front();
        check("rf_we", rf_we_out, 1);
        check("rf_rd", rf_rd_out, w.rd);
        check("rf_wd", rf_wd_out, w.wd);
        m_rf[w.rd] = w.wd;
      end else if (rf_we_out) begin
        check("rf_we_spurious", rf_we_out, 0);
      end
    end
  end

  task automatic drive(bit ev, logic [4:0] erd, logic [31:0] ewd,
                       bit mv, logic [4:0] mrd, logic [31:0] mwd,
                       bit iv, logic [4:0] ird, logic [4:0] ra, logic [4:0] rb);
    bit   eg, mg;
    chk_t c;
    wr_t  w;
    @(posedge clk_in); #1;
    ex_valid_in = ev;  ex_rd_in = erd;  ex_wd_in = ewd;
    mem_valid_in = mv; mem_rd_in = mrd; mem_wd_in = mwd;
    issue_valid_in = iv; issue_rd_in = ird;
    ra_in = ra; rb_in = rb;
    eg = ev && (!mv || m_last);
    mg = mv && (!ev || !m_last);
    c.cyc = cyc; c.ex_r = eg; c.mem_r = mg; c.ra_b = m_pend[ra]; c.rb_b = m_pend[rb];
    chk_q.push_back(c);
    if (m_clr_v) m_pend[m_clr_rd] = 1'b0;
    if (iv && ird != 0) m_pend[ird] = 1'b1;
    m_clr_v = 1'b0;
    if (eg || mg) begin
      m_last = mg;
      w.cyc = cyc + 1;
      w.rd  = eg ? erd : mrd;
      w.wd  = eg ? ewd : mwd;
      if (w.rd != 0) begin
        wr_q.push_back(w);
        m_clr_v  = 1'b1;
        m_clr_rd = w.rd;
      end
    end
  endtask

  task automatic idle(logic [4:0] ra, logic [4:0] rb);
    drive(0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b0;
    ex_valid_in = 1; ex_rd_in = 5'd2; ex_wd_in = 32'h1111_2222;
    mem_valid_in = 1; mem_rd_in = 5'd4; mem_wd_in = 32'h3333_4444;
    issue_valid_in = 1; issue_rd_in = 5'd4; ra_in = 5'd4; rb_in = 5'd2;
    repeat (3) @(posedge clk_in);
    #2;
    check("rst_ex_ready", ex_ready_out, 0);
    check("rst_mem_ready", mem_ready_out, 0);
    check("rst_rf_we", rf_we_out, 0);
    check("rst_rf_rd", rf_rd_out, 0);
    check("rst_rf_wd", rf_wd_out, 0);
    check("rst_ra_busy", ra_busy_out, 0);
    check("rst_rb_busy", rb_busy_out, 0);
    m_last = 1'b1;
    m_clr_v = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    wr_q.delete();
    chk_q.delete();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    ex_valid_in = 0; mem_valid_in = 0; issue_valid_in = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    do_reset();

    // Round-robin with both requesters valid: EX, MEM, EX, MEM.
    repeat (4) drive(1, 5, 32'hAAAA_0000, 1, 6, 32'h5555_FFFF, 0, 0, 5, 6);
    idle(0, 0);

    // Consumed rd=0 write produces no regfile write.
    drive(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);

    // RAW hazard on x7 cleared by a MEM write.
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0);
    drive(0, 0, 0, 1, 7, 32'h0000_0777, 0, 0, 7, 0);
    idle(7, 0);
    idle(7, 0);

    // Set/clear collision on x9: reissue during the write cycle keeps it pending.
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    idle(9, 9);
    drive(0, 0, 0, 1, 9, 32'h9999_0001, 0, 0, 9, 9);
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
    idle(9, 9);
    drive(1, 9, 32'h9999_0002, 0, 0, 0, 0, 0, 9, 0);
    idle(9, 0);
    idle(9, 0);

    // Async reset while a write to x3 is on the port.
    drive(1, 3, 32'h3333_0003, 0, 0, 0, 0, 0, 3, 0);
    idle(3, 0);
    #2;
    mon_en = 1'b0;
    check("t6_we_before_rst", rf_we_out, 1);
    rst_n_in = 1'b0;
    #1;
    check("t6_we_async_drop", rf_we_out, 0);
    do_reset();
    check("t6_x3_unchanged", tb_rf[3], m_rf[3]);
    idle(3, 3);
    drive(1, 8, 32'h0808_0808, 1, 10, 32'h1010_1010, 0, 0, 3, 8);

    for (int i = 0; i < 600; i++) begin : rnd
      bit         ev, mv, iv;
      logic [4:0] erd, mrd, ird, ra, rb;
      ev  = ($urandom_range(0, 2) != 0);
      mv  = ($urandom_range(0, 2) != 0);
      erd = 5'($urandom_range(0, 31));
      mrd = 5'($urandom_range(0, 31));
      ird = 5'($urandom_range(1, 31));
      iv  = ($urandom_range(0, 2) == 0) && !m_pend[ird];
      ra  = 5'($urandom_range(0, 31));
      rb  = 5'($urandom_range(0, 31));
      drive(ev, erd, $urandom, mv, mrd, $urandom, iv, ird, ra, rb);
    end

    repeat (3) idle(0, 0);
    @(posedge clk_in); #1;
    check("wr_q_drained", wr_q.size(), 0);
    for (int r = 1; r < 32; r++) check($sformatf("regfile_x%0d", r), tb_rf[r], m_rf[r]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
